// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the digit-serial magnitude comparator: FSM state
// encoding and the width helper for the digit counter.
package seq_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    CMP_IDLE = 2'd0,
    CMP_RUN  = 2'd1,
    CMP_DONE = 2'd2
  } cmp_state_t;

  function automatic int cmp_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_digit.sv
// One digit of the magnitude compare: purely combinational gt/lt of two
// DIGIT-bit unsigned slices (equality is implied by neither being set).
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    gt = (x > y);
    lt = (x < y);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with start/busy/done handshake,
// unsigned or two's-complement operands and optional early exit.
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? cmp_clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}} >> 0;

  if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
    $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
  end

  cmp_state_t       state, state_next;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0]    cnt;
  logic             gt_f, lt_f;
  logic             dgt, dlt;
  logic             accept, last, decide;
  logic             gt_now, lt_now;

  digit_compare #(.DIGIT(DIGIT)) u_digit (
    .x  (sa[WIDTH-1 -: DIGIT]),
    .y  (sb[WIDTH-1 -: DIGIT]),
    .gt (dgt),
    .lt (dlt)
  );

  always_comb begin
    accept = start && (state != CMP_RUN);
    last   = (cnt == CW'(NDIG - 1));
    // Once a digit has differed the sticky flags own the result.
    if (gt_f || lt_f) begin
      gt_now = gt_f;
      lt_now = lt_f;
    end else begin
      gt_now = dgt;
      lt_now = dlt;
    end
    decide = last || ((EARLY_EXIT != 0) && (dgt || dlt));
  end

  always_comb begin
    state_next = state;
    case (state)
      CMP_IDLE: if (accept) state_next = CMP_RUN;
      CMP_RUN:  if (decide) state_next = CMP_DONE;
      CMP_DONE: state_next = accept ? CMP_RUN : CMP_IDLE;
      default:  state_next = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= CMP_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      cnt  <= '0;
      gt_f <= 1'b0;
      lt_f <= 1'b0;
      g    <= 1'b0;
      e    <= 1'b0;
      l    <= 1'b0;
    end else if (accept) begin
      // Flipping the sign bit maps two's complement onto offset binary.
      sa   <= a ^ (signed_mode ? MSB : '0);
      sb   <= b ^ (signed_mode ? MSB : '0);
      cnt  <= '0;
      gt_f <= 1'b0;
      lt_f <= 1'b0;
      g    <= 1'b0;
      e    <= 1'b0;
      l    <= 1'b0;
    end else if (state == CMP_RUN) begin
      sa   <= sa << DIGIT;
      sb   <= sb << DIGIT;
      cnt  <= cnt + CW'(1);
      gt_f <= gt_now;
      lt_f <= lt_now;
      if (decide) begin
        g <= gt_now;
        l <= lt_now;
        e <= ~(gt_now | lt_now);
      end
    end
  end

  always_comb begin
    busy = (state == CMP_RUN);
    done = (state == CMP_DONE);
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench for seq_magnitude_comparator: three configurations driven in parallel,
// an arithmetic reference model checked every cycle, plus literal expectations.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  busy_v, done_v, g_v, e_v, l_v;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam int PW [3] = '{16, 16, 8};
  localparam int PD [3] = '{4, 4, 8};
  localparam int PE [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
    .g(g_v[0]), .e(e_v[0]), .l(l_v[0]));

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
    .g(g_v[1]), .e(e_v[1]), .l(l_v[1]));

  seq_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a[7:0]), .b(b[7:0]), .busy(busy_v[2]), .done(done_v[2]),
    .g(g_v[2]), .e(e_v[2]), .l(l_v[2]));

  // Cycles from accept to done: index of the first differing digit + 1 with
  // early exit, otherwise the full digit count.
  function automatic int lat_of(input logic [15:0] x, input logic [15:0] y,
                                input int w, input int d, input int ee);
    logic [15:0] diff;
    int msb;
    diff = x ^ y;
    msb = -1;
    for (int i = 0; i < w; i++) if (diff[i]) msb = i;
    if (ee == 0 || msb < 0) return w / d;
    return (w - 1 - msb) / d + 1;
  endfunction

  function automatic logic [2:0] res_of(input logic [15:0] x, input logic [15:0] y,
                                        input logic sm, input int w);
    longint va, vb, mask;
    mask = (longint'(1) << w) - 1;
    va = longint'(x) & mask;
    vb = longint'(y) & mask;
    if (sm && va[w-1]) va = va - (longint'(1) << w);
    if (sm && vb[w-1]) vb = vb - (longint'(1) << w);
    return {va > vb, va == vb, va < vb};
  endfunction

  int         m_ph  [3] = '{0, 0, 0};  // 0 idle, 1 run, 2 done
  int         m_rem [3] = '{0, 0, 0};
  logic [2:0] m_o   [3] = '{3'b0, 3'b0, 3'b0};
  logic [2:0] m_res [3] = '{3'b0, 3'b0, 3'b0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic int         ph = m_ph[i];
      automatic int         rm = m_rem[i];
      automatic logic [2:0] o  = m_o[i];
      automatic logic [2:0] rs = m_res[i];
      automatic bit         acc;
      if (!rst_n) begin
        ph = 0; rm = 0; o = '0;
      end else begin
        acc = start && (ph != 1);
        if (ph == 1) begin
          rm = rm - 1;
          if (rm == 0) begin ph = 2; o = rs; end
        end else if (ph == 2) begin
          ph = 0;
        end
        if (acc) begin
          ph = 1;
          rm = lat_of(a, b, PW[i], PD[i], PE[i]);
          rs = res_of(a, b, signed_mode, PW[i]);
          o  = '0;
        end
      end
      m_ph[i]  <= ph;
      m_rem[i] <= rm;
      m_o[i]   <= o;
      m_res[i] <= rs;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({busy_v[i], done_v[i], g_v[i], e_v[i], l_v[i]} !==
            {m_ph[i] == 1, m_ph[i] == 2, m_o[i]}) begin
          errors++;
          $display("FAIL model_u%0d busy,done,g,e,l got %b exp %b at %0t", i,
                   {busy_v[i], done_v[i], g_v[i], e_v[i], l_v[i]},
                   {m_ph[i] == 1, m_ph[i] == 2, m_o[i]}, $time);
        end
      end
    end
  end

  task automatic expect_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, act, exp);
    end
  endtask

  // Pulse start across one rising edge; returns at the falling edge after it.
  task automatic go(input logic [15:0] x, input logic [15:0] y, input logic sm);
    @(negedge clk);
    a = x; b = y; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done on instance idx; expired budget reports 99.
  task automatic wait_done(input int idx, output int n);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      if (done_v[idx]) break;
      if (n >= 20) begin n = 99; break; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n, cnt_done, cnt_busy;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_lit("reset_outputs", {busy_v[0], done_v[0], g_v[0], e_v[0], l_v[0]}, 0);
    chk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // MSB digit differs: one cycle with early exit
    go(16'h8000, 16'h7FFF, 1'b0);
    wait_done(0, n);
    expect_lit("t1_latency", n, 1);
    expect_lit("t1_gel", {g_v[0], e_v[0], l_v[0]}, 3'b100);
    idle(8);

    // LSB digit differs: four cycles in both modes
    go(16'h1230, 16'h1231, 1'b0);
    wait_done(0, n);
    expect_lit("t2_latency", n, 4);
    expect_lit("t2_gel", {g_v[0], e_v[0], l_v[0]}, 3'b001);
    expect_lit("t2_noearly", {done_v[1], g_v[1], e_v[1], l_v[1]}, 4'b1001);
    idle(8);

    go(16'hFFFF, 16'h0001, 1'b1);
    wait_done(0, n);
    expect_lit("t3_signed_gel", {g_v[0], e_v[0], l_v[0]}, 3'b001);
    idle(8);
    go(16'hFFFF, 16'h0001, 1'b0);
    wait_done(0, n);
    expect_lit("t3_unsigned_gel", {g_v[0], e_v[0], l_v[0]}, 3'b100);
    idle(8);

    // Equal operands, then a new start during the DONE cycle
    go(16'hA5A5, 16'hA5A5, 1'b0);
    wait_done(0, n);
    expect_lit("t4_latency", n, 4);
    expect_lit("t4_eq", {g_v[0], e_v[0], l_v[0], g_v[1], e_v[1], l_v[1]}, 6'b010010);
    a = 16'h0001; b = 16'h0000; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect_lit("t4_restart_busy", busy_v[0], 1);
    wait_done(0, n);
    expect_lit("t4_restart_latency", n, 4);
    expect_lit("t4_restart_gel", {g_v[0], e_v[0], l_v[0]}, 3'b100);
    idle(8);

    // Start during RUN is ignored
    go(16'h0003, 16'h0005, 1'b0);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        cnt_done++;
        expect_lit("t5_gel", {g_v[0], e_v[0], l_v[0]}, 3'b001);
      end
      if (busy_v[0]) cnt_busy++;
    end
    expect_lit("t5_done_count", cnt_done, 1);
    expect_lit("t5_busy_count", cnt_busy, 2);
    idle(4);

    // Reset mid-RUN aborts without a done pulse
    go(16'h0003, 16'h0005, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    expect_lit("t6_reset_abort", {busy_v[0], done_v[0], g_v[0], e_v[0], l_v[0]}, 0);
    rst_n = 1'b1;
    cnt_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_v[0]) cnt_done++;
    end
    expect_lit("t6_no_done", cnt_done, 0);
    idle(2);

    // WIDTH == DIGIT instance: single-cycle compare
    go(16'h0009, 16'h0009, 1'b0);
    wait_done(2, n);
    expect_lit("t6_w8_latency", n, 1);
    expect_lit("t6_w8_gel", {g_v[2], e_v[2], l_v[2]}, 3'b010);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
